// File: rtl/change_dispenser_if.sv
// ============================================================================
//  Module      : change_dispenser_if
//  Description : Request/load/hopper bundle between the change dispenser and
//                its environment (vending controller plus coin hopper).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface change_dispenser_if #(
    parameter int AMT_W = 6,
    parameter int CNT_W = 6
) ();
    logic             req;
    logic [AMT_W-1:0] amount;
    logic             hop_ready;
    logic             load_en;
    logic [CNT_W-1:0] load_q;
    logic [CNT_W-1:0] load_d;
    logic [CNT_W-1:0] load_n;
    logic             Q_out;
    logic             D_out;
    logic             N_out;
    logic             busy;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] remain;
    logic [CNT_W-1:0] inv_q;
    logic [CNT_W-1:0] inv_d;
    logic [CNT_W-1:0] inv_n;

    // Environment side: issues requests, loads inventory, models the hopper.
    modport master (
        output req, amount, hop_ready, load_en, load_q, load_d, load_n,
        input  Q_out, D_out, N_out, busy, done, short, remain,
               inv_q, inv_d, inv_n
    );

    // Dispenser side.
    modport slave (
        input  req, amount, hop_ready, load_en, load_q, load_d, load_n,
        output Q_out, D_out, N_out, busy, done, short, remain,
               inv_q, inv_d, inv_n
    );
endinterface

`default_nettype wire

// File: rtl/change_dispenser.sv
// ============================================================================
//  Module      : change_dispenser
//  Description : Greedy change dispenser (Q, then D, then N) with inventory
//                counters and a hopper handshake; reports short/remainder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module change_dispenser #(
    parameter int AMT_W   = 6,
    parameter int CNT_W   = 6,
    parameter int Q_INIT  = 4,
    parameter int D_INIT  = 4,
    parameter int N_INIT  = 4,
    parameter int GAP_CYC = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    change_dispenser_if.slave  bus
);

    // Gap counter only ever holds GAP_CYC-1 down to 0.
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_SELECT = 3'd1;
    localparam logic [2:0] c_S_ISSUE  = 3'd2;
    localparam logic [2:0] c_S_GAP    = 3'd3;
    localparam logic [2:0] c_S_DONE   = 3'd4;

    localparam logic [1:0] c_COIN_NONE = 2'd0;
    localparam logic [1:0] c_COIN_Q    = 2'd1;
    localparam logic [1:0] c_COIN_D    = 2'd2;
    localparam logic [1:0] c_COIN_N    = 2'd3;

    // Coin values in nickel units.
    localparam logic [AMT_W-1:0] c_VAL_Q = AMT_W'(5);
    localparam logic [AMT_W-1:0] c_VAL_D = AMT_W'(2);
    localparam logic [AMT_W-1:0] c_VAL_N = AMT_W'(1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [AMT_W-1:0] r_rem;
    logic [1:0]       r_sel;
    logic [GAP_W-1:0] r_gap;
    logic [CNT_W-1:0] r_inv_q;
    logic [CNT_W-1:0] r_inv_d;
    logic [CNT_W-1:0] r_inv_n;
    logic             r_short;
    logic [AMT_W-1:0] r_remain;
    logic             r_q_out;
    logic             r_d_out;
    logic             r_n_out;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_pick;
    logic [AMT_W-1:0] w_coin_val;
    logic             w_fire;
    logic             w_q_nxt;
    logic             w_d_nxt;
    logic             w_n_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    // Greedy choice for the current remainder; an empty counter is never picked.
    always_comb begin
        w_pick = c_COIN_NONE;
        if (r_rem >= c_VAL_Q && r_inv_q != '0) begin
            w_pick = c_COIN_Q;
        end else if (r_rem >= c_VAL_D && r_inv_d != '0) begin
            w_pick = c_COIN_D;
        end else if (r_rem >= c_VAL_N && r_inv_n != '0) begin
            w_pick = c_COIN_N;
        end
    end

    // Value of the coin currently being issued.
    always_comb begin
        case (r_sel)
            c_COIN_Q: w_coin_val = c_VAL_Q;
            c_COIN_D: w_coin_val = c_VAL_D;
            c_COIN_N: w_coin_val = c_VAL_N;
            default:  w_coin_val = '0;
        endcase
    end

    assign w_fire = (r_state == c_S_ISSUE) && bus.hop_ready;

    // State register plus the registered copies of all control outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_q_out <= 1'b0;
            r_d_out <= 1'b0;
            r_n_out <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q_out <= w_q_nxt;
            r_d_out <= w_d_nxt;
            r_n_out <= w_n_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state decode; a load in IDLE takes priority over a request.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (!bus.load_en && bus.req) begin
                    w_state_nxt = c_S_SELECT;
                end
            end
            c_S_SELECT: begin
                w_state_nxt = (w_pick == c_COIN_NONE) ? c_S_DONE : c_S_ISSUE;
            end
            c_S_ISSUE: begin
                if (bus.hop_ready) begin
                    w_state_nxt = c_S_GAP;
                end
            end
            c_S_GAP: begin
                if (r_gap == '0) begin
                    w_state_nxt = c_S_SELECT;
                end
            end
            c_S_DONE: begin
                w_state_nxt = c_S_IDLE;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // Output decode: values the output registers take at the next edge.
    always_comb begin
        w_q_nxt    = w_fire && (r_sel == c_COIN_Q);
        w_d_nxt    = w_fire && (r_sel == c_COIN_D);
        w_n_nxt    = w_fire && (r_sel == c_COIN_N);
        w_busy_nxt = (w_state_nxt != c_S_IDLE);
        w_done_nxt = (w_state_nxt == c_S_DONE);
    end

    // Datapath: remainder, selected coin, gap timer, inventory and result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem    <= '0;
            r_sel    <= c_COIN_NONE;
            r_gap    <= '0;
            r_inv_q  <= CNT_W'(Q_INIT);
            r_inv_d  <= CNT_W'(D_INIT);
            r_inv_n  <= CNT_W'(N_INIT);
            r_short  <= 1'b0;
            r_remain <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (bus.load_en) begin
                        r_inv_q <= bus.load_q;
                        r_inv_d <= bus.load_d;
                        r_inv_n <= bus.load_n;
                    end else if (bus.req) begin
                        r_rem    <= bus.amount;
                        r_short  <= 1'b0;
                        r_remain <= '0;
                    end
                end
                c_S_SELECT: begin
                    // Result is published on entry to DONE so it lines up with done.
                    if (w_pick == c_COIN_NONE) begin
                        r_short  <= (r_rem != '0);
                        r_remain <= r_rem;
                    end else begin
                        r_sel <= w_pick;
                    end
                end
                c_S_ISSUE: begin
                    if (bus.hop_ready) begin
                        r_rem <= r_rem - w_coin_val;
                        r_gap <= GAP_W'(GAP_CYC - 1);
                        case (r_sel)
                            c_COIN_Q: r_inv_q <= r_inv_q - 1'b1;
                            c_COIN_D: r_inv_d <= r_inv_d - 1'b1;
                            c_COIN_N: r_inv_n <= r_inv_n - 1'b1;
                            default:  ;
                        endcase
                    end
                end
                c_S_GAP: begin
                    if (r_gap != '0) begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Q_out  = r_q_out;
    assign bus.D_out  = r_d_out;
    assign bus.N_out  = r_n_out;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.short  = r_short;
    assign bus.remain = r_remain;
    assign bus.inv_q  = r_inv_q;
    assign bus.inv_d  = r_inv_d;
    assign bus.inv_n  = r_inv_n;

endmodule

`default_nettype wire

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Return-side companion to the vending controller: takes a change amount and drives the coin hopper with one-cycle N_out/D_out/Q_out pulses.
- Greedy coin selection (quarter, then dime, then nickel), limited by per-denomination inventory counters.
- Handshakes with the hopper; reports completion, shortfall and any undispensed remainder.

Parameters:
AMT_W, 6, width of amount/remain in nickel units (5 cents each)
CNT_W, 6, width of each inventory counter
Q_INIT, 4, quarter count after reset
D_INIT, 4, dime count after reset
N_INIT, 4, nickel count after reset
GAP_CYC, 2, cycles from a coin pulse to the next selection (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
req  in  1  start request, sampled in IDLE only
amount  in  AMT_W  change owed in nickel units, sampled with req
hop_ready  in  1  hopper can accept a coin this cycle
load_en  in  1  inventory load strobe, IDLE only
load_q  in  CNT_W  quarter count to load
load_d  in  CNT_W  dime count to load
load_n  in  CNT_W  nickel count to load
Q_out  out  1  one-cycle quarter eject pulse
D_out  out  1  one-cycle dime eject pulse
N_out  out  1  one-cycle nickel eject pulse
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
short  out  1  exact change not possible; valid with done, held until next accepted req
remain  out  AMT_W  undispensed amount; valid with done, held until next accepted req
inv_q, inv_d, inv_n  out  CNT_W each  current inventory

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on port reset.
- All outputs are registered.
- Reset values:
  - state IDLE.
  - Q_out, D_out, N_out, busy, done, short = 0.
  - remain = 0.
  - inv_q = Q_INIT, inv_d = D_INIT, inv_n = N_INIT.
- Reset mid-dispense: aborts immediately. No done pulse. Inventory returns to the INIT values.
- Coin values in nickel units: Q = 5, D = 2, N = 1.
- States:
  - IDLE
    - load_en=1: inventories take load_q/d/n at the next edge. A req in the same cycle is dropped (load wins).
    - Otherwise req=1: internal rem <= amount, short <= 0, remain <= 0; go to SELECT.
  - SELECT (one cycle), first match wins:
    - rem == 0 → DONE, short=0.
    - rem >= 5 and inv_q > 0 → ISSUE(Q).
    - rem >= 2 and inv_d > 0 → ISSUE(D).
    - rem >= 1 and inv_n > 0 → ISSUE(N).
    - Otherwise → DONE, short=1.
  - ISSUE: waits while hop_ready=0, with no timeout. On hop_ready=1 at an edge:
    - the selected coin output goes high for the next cycle only;
    - rem decrements by the coin value;
    - that inventory counter decrements by 1;
    - go to GAP.
  - GAP: lasts GAP_CYC cycles, then SELECT. The coin output is high only in the first GAP cycle.
  - DONE: done=1 for one cycle; remain <= rem; short as decided in SELECT; then IDLE.
- At most one coin output is high in any cycle.
- Coins always go out in the order Q, then D, then N.
- Inventory never underflows: a counter at 0 is never selected.
- req while busy: ignored. load_en while busy: ignored.
- amount = 0: SELECT → DONE; done pulses with short=0 and remain=0, no coins.
- Greedy selection is final. A case that a non-greedy choice could satisfy still reports short (e.g. rem=6 with q=1, d=3, n=0 → Q, then short with remain=1).
- Latency with hop_ready held 1:
  - req sampled at edge t;
  - first coin pulse is high in the cycle after edge t+2;
  - each further coin costs GAP_CYC+2 cycles;
  - done follows the final GAP plus one SELECT cycle.

Test Plan:
- Reset: assert reset 2 cycles → inv_q/d/n = 4/4/4; all pulses, busy, done, short = 0; remain = 0.
- amount=8 (40c), hop_ready=1 → Q_out, D_out, N_out once each in that order, each 1 cycle wide and non-overlapping → done=1, short=0, remain=0, inventory 3/3/3.
- Load q=0, d=3, n=0; amount=6 → three D_out pulses → done, short=0, inv_d=0; a req in the load cycle is dropped (no busy).
- Load q=0, d=1, n=0; amount=3 → one D_out → done, short=1, remain=1, inv_d=0.
- amount=5; hold hop_ready=0 for 10 cycles after SELECT → no coin, busy=1 throughout, extra req pulses ignored; release → single Q_out, done.
- amount=8; assert reset the cycle after the first Q_out → next cycle all outputs 0, no done pulse, inventory 4/4/4.
